// File: rtl/restoring_divider_ctrl.sv
// restoring_divider_ctrl
//   Unsigned 8-bit / 4-bit restoring divider controller. One shift/subtract
//   step per clock, MSB first, behind a start/done handshake. Results and the
//   divide-by-zero flag are registered and held until the next accepted start.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request; sampled only in IDLE
//   dividend     8-bit unsigned dividend, captured on the accepting edge
//   divisor      4-bit unsigned divisor, captured on the accepting edge
//   busy         high while iterating (CALC)
//   done         one-cycle pulse, results valid from this cycle onward
//   quotient     8-bit quotient (8'hFF on divide-by-zero)
//   remainder    4-bit remainder
//   div_by_zero  set with done when the captured divisor was zero
//
// state  | meaning
// S_IDLE | waiting for start
// S_CALC | eight restoring iterations, counter 0..7
// S_DONE | single-cycle done pulse, then back to IDLE
module restoring_divider_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  // Dividend bits shift out of the top while quotient bits shift in at the
  // bottom, so after eight steps this register holds the quotient.
  logic [7:0] r_shift;
  logic [3:0] r_divisor;
  // Partial remainder. It is always below the divisor between steps, so its
  // fifth bit is permanently zero and is not stored.
  logic [3:0] r_rem;
  logic [2:0] r_cnt;
  logic [7:0] r_quot;
  logic [3:0] r_remainder;
  logic       r_dbz;

  logic       w_accept;
  logic       w_zero;
  logic       w_last;
  logic [4:0] w_rs;
  logic       w_borrow;
  logic [3:0] w_t;
  logic [3:0] w_rem_next;
  logic       w_qbit;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_zero   = (divisor == 4'd0);
  assign w_last   = (r_state == S_CALC) && (r_cnt == 3'd7);

  // Trial subtraction Rs - {0,divisor}. The borrow is the 5-bit compare;
  // when there is no borrow the true difference is below the divisor, so
  // the low four bits of the modular difference are exact.
  assign w_rs       = {r_rem, r_shift[7]};
  assign w_borrow   = (w_rs < {1'b0, r_divisor});
  assign w_t        = w_rs[3:0] - r_divisor;
  assign w_rem_next = w_borrow ? w_rs[3:0] : w_t;
  assign w_qbit     = ~w_borrow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = w_zero ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        busy = 1'b1;
        if (r_cnt == 3'd7) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift     <= 8'h00;
      r_divisor   <= 4'h0;
      r_rem       <= 4'h0;
      r_cnt       <= 3'd0;
      r_quot      <= 8'h00;
      r_remainder <= 4'h0;
      r_dbz       <= 1'b0;
    end else if (w_accept) begin
      if (w_zero) begin
        r_quot      <= 8'hFF;
        r_remainder <= 4'h0;
        r_dbz       <= 1'b1;
      end else begin
        r_shift     <= dividend;
        r_divisor   <= divisor;
        r_rem       <= 4'h0;
        r_cnt       <= 3'd0;
        r_quot      <= 8'h00;
        r_remainder <= 4'h0;
        r_dbz       <= 1'b0;
      end
    end else if (r_state == S_CALC) begin
      r_shift <= {r_shift[6:0], w_qbit};
      r_rem   <= w_rem_next;
      r_cnt   <= r_cnt + 3'd1;
      if (w_last) begin
        r_quot      <= {r_shift[6:0], w_qbit};
        r_remainder <= w_rem_next;
      end
    end
  end

  assign quotient    = r_quot;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_restoring_divider_ctrl.sv
module tb_restoring_divider_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int n_checks;
  int n_errors;

  restoring_divider_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
  task automatic do_op(input logic [7:0] dvd, input logic [3:0] dvs,
                       output logic [7:0] q, output logic [3:0] r, output logic z,
                       output int lat, output int bcnt);
    start    = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
    lat  = 0;
    bcnt = 0;
    while (!done && lat < 30) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    if (!done) check_val("op_timeout", 32'd0, 32'd1);
    q = quotient;
    r = remainder;
    z = div_by_zero;
    check_val("busy_at_done", busy, 0);
    @(posedge clk); #1;
    check_val("done_one_cycle", done, 0);
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] dvd;
    logic [3:0] dvs;
    logic [7:0] q;
    logic [3:0] r;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    int         lat;
    int         bcnt;
    int         done_seen;
    int         off;
    vec_t       vecs[5];

    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 4'd0;

    #3;
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_q", quotient, 0);
    check_val("rst_r", remainder, 0);
    check_val("rst_dbz", div_by_zero, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 100 / 7 = 14 r 2 with timing
    do_op(8'd100, 4'd7, q, r, z, lat, bcnt);
    check_val("basic_latency", lat, 8);
    check_val("basic_busy_cycles", bcnt, 8);
    check_val("basic_q", q, 14);
    check_val("basic_r", r, 2);
    check_val("basic_dbz", z, 0);
    check_val("basic_q_held_idle", quotient, 14);

    vecs[0] = '{dvd: 8'd255, dvs: 4'd15, q: 8'd17,  r: 4'd0};
    vecs[1] = '{dvd: 8'd255, dvs: 4'd1,  q: 8'd255, r: 4'd0};
    vecs[2] = '{dvd: 8'd5,   dvs: 4'd9,  q: 8'd0,   r: 4'd5};
    vecs[3] = '{dvd: 8'd0,   dvs: 4'd3,  q: 8'd0,   r: 4'd0};
    vecs[4] = '{dvd: 8'd143, dvs: 4'd11, q: 8'd13,  r: 4'd0};
    for (int i = 0; i < 5; i++) begin
      do_op(vecs[i].dvd, vecs[i].dvs, q, r, z, lat, bcnt);
      check_val($sformatf("vec%0d_q", i), q, vecs[i].q);
      check_val($sformatf("vec%0d_r", i), r, vecs[i].r);
      check_val($sformatf("vec%0d_dbz", i), z, 0);
      check_val($sformatf("vec%0d_lat", i), lat, 8);
    end

    // divide by zero
    do_op(8'd200, 4'd0, q, r, z, lat, bcnt);
    check_val("dbz_latency", lat, 0);
    check_val("dbz_busy_cycles", bcnt, 0);
    check_val("dbz_flag", z, 1);
    check_val("dbz_q", q, 8'hFF);
    check_val("dbz_r", r, 0);
    check_val("dbz_held_idle", div_by_zero, 1);
    do_op(8'd9, 4'd3, q, r, z, lat, bcnt);
    check_val("after_dbz_q", q, 3);
    check_val("after_dbz_r", r, 0);
    check_val("after_dbz_flag", z, 0);

    // start held high through CALC and DONE with new operands
    start    = 1'b1;
    dividend = 8'd100;
    divisor  = 4'd7;
    @(posedge clk); #1;
    dividend = 8'd50;
    divisor  = 4'd5;
    lat = 0;
    while (!done && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    check_val("hold_first_lat", lat, 8);
    check_val("hold_first_q", quotient, 14);
    check_val("hold_first_r", remainder, 2);
    @(posedge clk); #1;
    check_val("hold_idle_done", done, 0);
    check_val("hold_idle_busy", busy, 0);
    check_val("hold_idle_q", quotient, 14);
    @(posedge clk); #1;
    check_val("hold_accept_busy", busy, 1);
    check_val("hold_accept_clear_q", quotient, 0);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    check_val("hold_second_lat", lat, 8);
    check_val("hold_second_q", quotient, 10);
    check_val("hold_second_r", remainder, 0);
    @(posedge clk); #1;
    @(negedge clk);

    // async reset in the middle of an operation
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_val("midrst_busy_before", busy, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("midrst_busy", busy, 0);
    check_val("midrst_done", done, 0);
    check_val("midrst_q", quotient, 0);
    check_val("midrst_r", remainder, 0);
    check_val("midrst_dbz", div_by_zero, 0);
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) done_seen++;
      if (i == 2) rst_n = 1'b1;
    end
    check_val("midrst_no_done", done_seen, 0);
    check_val("midrst_idle_busy", busy, 0);
    do_op(8'd200, 4'd3, q, r, z, lat, bcnt);
    check_val("postrst_q", q, 66);
    check_val("postrst_r", r, 2);

    // exhaustive dividend sweep in a randomised order per divisor
    for (int d = 1; d < 16; d++) begin
      off = $urandom_range(0, 255);
      for (int i = 0; i < 256; i++) begin
        logic [7:0] dvd;
        dvd = 8'((i + off) % 256);
        do_op(dvd, 4'(d), q, r, z, lat, bcnt);
        check_val($sformatf("sweep_inv_%0d_%0d", dvd, d), 32'(q) * 32'(d) + 32'(r), 32'(dvd));
        check_val($sformatf("sweep_rlt_%0d_%0d", dvd, d), 32'(r < 4'(d)), 32'd1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
